uart_tx_buffer: RTL and testbench
=================================

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 The block SHALL have parameter DBIT, default 8, giving the data byte width.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the FIFO entry count; it must be a power of two and at least 2.
REQ-003 The block SHALL have port clk  input  1  clock; all logic SHALL be on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port wr_en  input  1  write strobe from the producer.
REQ-006 The block SHALL have port wr_data  input  DBIT  byte to enqueue.
REQ-007 The block SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-008 The block SHALL have port empty  output  1  FIFO holds 0 entries.
REQ-009 The block SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-010 The block SHALL have port tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-011 The block SHALL have port din  output  DBIT  byte presented to the UART transmitter.
REQ-012 The block SHALL have port tx_done_tick  input  1  one-cycle completion pulse from the UART transmitter.
REQ-013 The block SHALL have port busy  output  1  high whenever the FSM is not in ST_IDLE.
REQ-014 The block SHALL have port overflow  output  1  sticky flag for a dropped write.
REQ-015 The block SHALL have port drop_cnt  output  8  count of dropped writes.

Function
REQ-016 The FSM SHALL have states ST_IDLE, ST_LOAD, ST_START and ST_WAIT.
REQ-017 In ST_IDLE, the FSM SHALL go to ST_LOAD when empty is 0 and SHALL stay in ST_IDLE otherwise.
REQ-018 ST_LOAD SHALL register din from the head entry, advance rd_ptr, decrement the occupancy and go to ST_START.
REQ-019 ST_START SHALL assert tx_start for exactly one cycle and go to ST_WAIT.
REQ-020 ST_WAIT SHALL go to ST_IDLE on tx_done_tick and SHALL stay in ST_WAIT otherwise.
REQ-021 tx_done_tick SHALL be ignored in every state except ST_WAIT.
REQ-022 din SHALL hold stable from the ST_LOAD edge until the next ST_LOAD.
REQ-023 A write accepted at edge N into an empty FIFO with the FSM in ST_IDLE SHALL produce tx_start high in the cycle after edge N+2.
REQ-024 A write SHALL be accepted when wr_en is 1 and full is 0 at the sampling edge; wr_ptr SHALL advance and the occupancy SHALL increment.
REQ-025 A write with full at 1 SHALL be dropped even if a pop occurs in the same cycle; FIFO contents and pointers SHALL be unchanged.
REQ-026 A write and a pop in the same cycle with the FIFO not full SHALL leave count unchanged, and both pointers SHALL advance.
REQ-027 Pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-028 full, empty and count SHALL be derived from one registered occupancy counter.
REQ-029 Bytes SHALL be transmitted in write order with no loss or duplication.
REQ-030 overflow SHALL set on the first dropped write and hold until reset.

Reset
REQ-031 On rst, the FSM SHALL go to ST_IDLE.
REQ-032 On rst, rd_ptr, wr_ptr and count SHALL be 0, with empty=1 and full=0.
REQ-033 On rst, din, tx_start, overflow and drop_cnt SHALL be 0, and busy SHALL be 0.
REQ-034 rst asserted mid-transmission SHALL discard all queued bytes and the in-flight byte, with no tx_start in the reset cycle or the following cycle.
REQ-035 FIFO storage SHALL NOT be reset.

Configuration
REQ-036 With macro UART_TXBUF_DROP_CNT_EN defined, drop_cnt SHALL increment by 1 per dropped write and saturate at 255.
REQ-037 With UART_TXBUF_DROP_CNT_EN undefined, drop_cnt SHALL be tied to 0, no counter logic SHALL be generated, and overflow SHALL behave identically.

Structure
REQ-038 Package uart_pkg SHALL hold the state_type enum (ST_IDLE, ST_LOAD, ST_START, ST_WAIT) and default constants DBIT=8 and TXBUF_DEPTH=16.
REQ-039 Storage, pointers and occupancy SHALL live in sub-module uart_fifo (push/pop/full/empty/count).
REQ-040 uart_tx_buffer SHALL instantiate uart_fifo and hold the FSM and the din register.

Verification
REQ-041 The bench SHALL cover a single write: write 8'h41 while idle -> tx_start pulses once 2 cycles later, din=8'h41, busy=1 until tx_done_tick, then busy=0 and empty=1.
REQ-042 The bench SHALL cover a burst: 5 back-to-back writes 8'h30..8'h34 with tx_done_tick returned 20 cycles after each tx_start -> exactly 5 tx_start pulses with din 8'h30..8'h34 in order, and count peaks at 4.
REQ-043 The bench SHALL cover fill and overflow: 17 writes with tx_done_tick withheld -> first byte in ST_WAIT, count=15 after the 16th write, 17th accepted, full=1; an 18th write is dropped, overflow=1, drop_cnt=1 with the macro and 0 without.
REQ-044 The bench SHALL cover a simultaneous write and pop: write while the FSM is in ST_LOAD with count=3 -> count stays 3, and order is preserved across pointer wrap after 40 total bytes.
REQ-045 The bench SHALL cover a stray tick: pulse tx_done_tick in ST_IDLE and in ST_START -> no state change and no extra pop.
REQ-046 The bench SHALL cover reset mid-operation: assert rst in ST_WAIT with count=6 -> next cycle ST_IDLE, count=0, din=0, overflow=0, and no tx_start until a new write.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_pkg : shared FSM state type and default sizes for uart_tx_buffer |
// | Rev 1.0  : initial release                                            |
// +-----------------------------------------------------------------------+
package uart_pkg;

  localparam int DBIT        = 8;
  localparam int TXBUF_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } state_type;

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_fifo : circular byte FIFO with a single registered occupancy     |
// |             counter driving full/empty/count                          |
// | Rev 1.0   : initial release                                           |
// +-----------------------------------------------------------------------+
module uart_fifo #(
  parameter int  DBIT  = 8,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [DBIT-1:0] wr_data,
  input  logic            pop,
  output logic [DBIT-1:0] rd_data,
  output logic            full,
  output logic            empty,
  output logic [AW:0]     count
);
  import uart_pkg::*;

  logic [DBIT-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_do_push;
  logic            w_do_pop;

  // A write into a full FIFO is refused even if a pop lands in the same cycle.
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign full    = (r_count == (AW+1)'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_tx_buffer : FIFO-fed launcher for a UART transmitter             |
// |   Optional macro UART_TXBUF_DROP_CNT_EN enables the saturating        |
// |   dropped-write counter on drop_cnt (tied to 0 otherwise).            |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
module uart_tx_buffer #(
  parameter int DBIT  = uart_pkg::DBIT,
  parameter int DEPTH = uart_pkg::TXBUF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DBIT-1:0]        wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   tx_start,
  output logic [DBIT-1:0]        din,
  input  logic                   tx_done_tick,
  output logic                   busy,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);
  import uart_pkg::*;

  state_type       r_state;
  logic            r_tx_start;
  logic            r_busy;
  logic            r_overflow;
  logic [DBIT-1:0] r_din;
  logic [DBIT-1:0] w_head;
  logic            w_pop;
  logic            w_drop;

  assign w_pop  = (r_state == ST_LOAD);
  assign w_drop = wr_en & full;

  uart_fifo #(
    .DBIT  (DBIT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_en),
    .wr_data (wr_data),
    .pop     (w_pop),
    .rd_data (w_head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // tx_start and busy are registered alongside the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_din      <= '0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!empty) begin
            r_state <= ST_LOAD;
            r_busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_din      <= w_head;
          r_tx_start <= 1'b1;
          r_state    <= ST_START;
        end
        ST_START: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (tx_done_tick) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

`ifdef UART_TXBUF_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst)                                r_drop_cnt <= 8'h00;
    else if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'h01;
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 8'h00;
`endif

  assign tx_start = r_tx_start;
  assign din      = r_din;
  assign busy     = r_busy;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | tb_uart_tx_buffer : self-checking bench for uart_tx_buffer            |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
module tb_uart_tx_buffer;
  localparam int DBIT  = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_TXBUF_DROP_CNT_EN
  localparam logic [7:0] EXP_DROP1 = 8'd1;
`else
  localparam logic [7:0] EXP_DROP1 = 8'd0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en = 1'b0;
  logic [DBIT-1:0] wr_data = '0;
  logic            man_tick = 1'b0;
  logic            auto_tick = 1'b0;
  logic            tx_done_tick;
  logic            full, empty, tx_start, busy, overflow;
  logic [CW-1:0]   count;
  logic [DBIT-1:0] din;
  logic [7:0]      drop_cnt;

  assign tx_done_tick = man_tick | auto_tick;

  always #5 clk = ~clk;

  uart_tx_buffer #(.DBIT(DBIT), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .tx_start     (tx_start),
    .din          (din),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Transmit-side observer: every start pulse and the byte it carried.
  logic [7:0] start_log[$];
  int         start_cnt = 0;
  int         dbl_start = 0;
  logic       prev_start = 1'b0;
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      start_log.push_back(din);
      start_cnt++;
      if (prev_start) dbl_start++;
    end
    prev_start = tx_start;
  end

  // Emulated UART: returns tx_done_tick a random latency after each start.
  bit auto_en = 1'b0;
  int lat_min = 1;
  int lat_max = 1;
  int cd      = 0;
  always @(negedge clk) begin
    auto_tick = 1'b0;
    if (!auto_en) cd = 0;
    else if (tx_start === 1'b1) cd = int'($urandom_range(lat_max, lat_min));
    else if (cd > 0) begin
      cd--;
      if (cd == 0) auto_tick = 1'b1;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_tick();
    man_tick = 1'b1;
    step();
    man_tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    start_log.delete();
    start_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (empty !== 1'b1)    begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0)     begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (count !== CW'(0))  begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    n_cmp++; if (din !== 8'h00)     begin n_fail++; $display("FAIL reset_din: got %h want 00", din); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_single_write();
    int         k_hit = -1;
    logic [7:0] seen  = 8'h00;
    do_reset();
    wr(8'h41);
    n_cmp++; if (count !== CW'(1)) begin n_fail++; $display("FAIL single_count: got %0d want 1", count); end
    for (int k = 0; k < 10; k++) begin
      if (tx_start === 1'b1 && k_hit < 0) begin k_hit = k; seen = din; end
      if (k == 1) begin
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_load: got %b want 1", busy); end
      end
      step();
    end
    n_cmp++; if (k_hit != 2)     begin n_fail++; $display("FAIL single_latency: got %0d want 2", k_hit); end
    n_cmp++; if (seen !== 8'h41) begin n_fail++; $display("FAIL single_din: got %h want 41", seen); end
    n_cmp++; if (start_cnt != 1) begin n_fail++; $display("FAIL single_pulses: got %0d want 1", start_cnt); end
    n_cmp++; if (busy !== 1'b1)  begin n_fail++; $display("FAIL single_busy_wait: got %b want 1", busy); end
    pulse_tick();
    n_cmp++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL single_busy_done: got %b want 0", busy); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty_done: got %b want 1", empty); end
  endtask

  task automatic test_burst();
    int t    = 0;
    int peak = 0;
    do_reset();
    lat_min = 20; lat_max = 20; auto_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr(8'h30 + 8'(i));
      if (int'(count) > peak) peak = int'(count);
    end
    for (t = 0; t < 400; t++) begin
      if (int'(count) > peak) peak = int'(count);
      if (start_cnt == 5 && busy === 1'b0) break;
      step();
    end
    auto_en = 1'b0;
    n_cmp++; if (t >= 400)       begin n_fail++; $display("FAIL burst_timeout: got %0d starts want 5", start_cnt); end
    n_cmp++; if (start_cnt != 5) begin n_fail++; $display("FAIL burst_pulses: got %0d want 5", start_cnt); end
    for (int i = 0; i < 5 && i < start_log.size(); i++) begin
      n_cmp++;
      if (start_log[i] !== 8'h30 + 8'(i)) begin
        n_fail++; $display("FAIL burst_order[%0d]: got %h want %h", i, start_log[i], 8'h30 + 8'(i));
      end
    end
    n_cmp++; if (peak != 4)      begin n_fail++; $display("FAIL burst_peak: got %0d want 4", peak); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL burst_empty: got %b want 1", empty); end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] b[18];
    int t = 0;
    do_reset();
    foreach (b[i]) b[i] = 8'($urandom);
    for (int i = 0; i < 17; i++) begin
      wr(b[i]);
      if (i == 15) begin
        n_cmp++; if (count !== CW'(15)) begin n_fail++; $display("FAIL fill_count16: got %0d want 15", count); end
      end
    end
    n_cmp++; if (full !== 1'b1)      begin n_fail++; $display("FAIL fill_full: got %b want 1", full); end
    n_cmp++; if (count !== CW'(16))  begin n_fail++; $display("FAIL fill_count17: got %0d want 16", count); end
    n_cmp++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL fill_no_ovf: got %b want 0", overflow); end
    n_cmp++; if (busy !== 1'b1)      begin n_fail++; $display("FAIL fill_busy: got %b want 1", busy); end
    wr(b[17]);
    n_cmp++; if (overflow !== 1'b1)  begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_cmp++; if (drop_cnt !== EXP_DROP1) begin n_fail++; $display("FAIL ovf_drop_cnt: got %0d want %0d", drop_cnt, EXP_DROP1); end
    n_cmp++; if (count !== CW'(16))  begin n_fail++; $display("FAIL ovf_count: got %0d want 16", count); end
    lat_min = 1; lat_max = 4; auto_en = 1'b1;
    pulse_tick();
    for (t = 0; t < 600; t++) begin
      if (start_cnt == 17 && busy === 1'b0) break;
      step();
    end
    auto_en = 1'b0;
    n_cmp++; if (t >= 600) begin n_fail++; $display("FAIL fill_drain_timeout: got %0d starts want 17", start_cnt); end
    for (int i = 0; i < 17 && i < start_log.size(); i++) begin
      n_cmp++;
      if (start_log[i] !== b[i]) begin n_fail++; $display("FAIL fill_order[%0d]: got %h want %h", i, start_log[i], b[i]); end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int t = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin b = 8'($urandom); exp_q.push_back(b); wr(b); end
    repeat (2) step();
    n_cmp++; if (count !== CW'(3)) begin n_fail++; $display("FAIL simul_pre_count: got %0d want 3", count); end
    pulse_tick();
    n_cmp++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL simul_idle: got %b want 0", busy); end
    step();
    n_cmp++; if (count !== CW'(3)) begin n_fail++; $display("FAIL simul_load_count: got %0d want 3", count); end
    lat_min = 1; lat_max = 3; auto_en = 1'b1;
    b = 8'($urandom); exp_q.push_back(b); wr(b);
    n_cmp++; if (count !== CW'(3))   begin n_fail++; $display("FAIL simul_count: got %0d want 3", count); end
    n_cmp++; if (tx_start !== 1'b1)  begin n_fail++; $display("FAIL simul_start: got %b want 1", tx_start); end
    for (int i = 5; i < 40; i++) begin
      for (int w = 0; w < 200 && int'(count) >= DEPTH - 2; w++) step();
      b = 8'($urandom); exp_q.push_back(b); wr(b);
    end
    for (t = 0; t < 1000; t++) begin
      if (start_cnt == 40 && busy === 1'b0) break;
      step();
    end
    auto_en = 1'b0;
    n_cmp++; if (t >= 1000) begin n_fail++; $display("FAIL simul_timeout: got %0d starts want 40", start_cnt); end
    for (int i = 0; i < 40 && i < start_log.size(); i++) begin
      n_cmp++;
      if (start_log[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_order[%0d]: got %h want %h", i, start_log[i], exp_q[i]); end
    end
  endtask

  task automatic test_stray_tick();
    logic [7:0] a, b;
    do_reset();
    a = 8'($urandom); b = 8'($urandom);
    pulse_tick();
    n_cmp++; if (busy !== 1'b0 || count !== CW'(0)) begin n_fail++; $display("FAIL stray_idle: got busy=%b count=%0d want 0/0", busy, count); end
    wr(a);
    wr(b);
    step();
    n_cmp++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL stray_start: got %b want 1", tx_start); end
    pulse_tick();
    repeat (3) step();
    n_cmp++; if (count !== CW'(1))  begin n_fail++; $display("FAIL stray_count: got %0d want 1", count); end
    n_cmp++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL stray_busy: got %b want 1", busy); end
    n_cmp++; if (start_cnt != 1)    begin n_fail++; $display("FAIL stray_pulses1: got %0d want 1", start_cnt); end
    pulse_tick();
    pulse_tick();
    repeat (3) step();
    n_cmp++; if (start_cnt != 2 || start_log.size() != 2) begin n_fail++; $display("FAIL stray_pulses2: got %0d want 2", start_cnt); end
    else begin
      n_cmp++; if (start_log[0] !== a || start_log[1] !== b) begin n_fail++; $display("FAIL stray_order: got %h %h want %h %h", start_log[0], start_log[1], a, b); end
    end
    pulse_tick();
    n_cmp++; if (busy !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL stray_final: got busy=%b empty=%b want 0/1", busy, empty); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] nb;
    int t = 0;
    do_reset();
    for (int i = 0; i < 7; i++) wr(8'($urandom));
    repeat (2) step();
    n_cmp++; if (count !== CW'(6) || busy !== 1'b1) begin n_fail++; $display("FAIL rmid_setup: got count=%0d busy=%b want 6/1", count, busy); end
    start_cnt = 0;
    rst = 1'b1;
    step();
    n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rmid_idle: got %b want 0", busy); end
    n_cmp++; if (count !== CW'(0))  begin n_fail++; $display("FAIL rmid_count: got %0d want 0", count); end
    n_cmp++; if (din !== 8'h00)     begin n_fail++; $display("FAIL rmid_din: got %h want 00", din); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rmid_ovf: got %b want 0", overflow); end
    n_cmp++; if (empty !== 1'b1)    begin n_fail++; $display("FAIL rmid_empty: got %b want 1", empty); end
    rst = 1'b0;
    pulse_tick();
    repeat (8) step();
    n_cmp++; if (start_cnt != 0)    begin n_fail++; $display("FAIL rmid_no_start: got %0d want 0", start_cnt); end
    start_log.delete();
    nb = 8'($urandom);
    wr(nb);
    for (t = 0; t < 20 && start_cnt == 0; t++) step();
    n_cmp++; if (start_log.size() != 1) begin n_fail++; $display("FAIL rmid_restart: got %0d starts want 1", start_log.size()); end
    else begin
      n_cmp++; if (start_log[0] !== nb) begin n_fail++; $display("FAIL rmid_byte: got %h want %h", start_log[0], nb); end
    end
    pulse_tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int t = 0;
    do_reset();
    dbl_start = 0;
    lat_min = 1; lat_max = 8; auto_en = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(1, 0) == 1 && int'(count) < DEPTH - 2) begin
        b = 8'($urandom); exp_q.push_back(b); wr(b);
      end else step();
    end
    for (t = 0; t < 2000; t++) begin
      if (start_cnt == exp_q.size() && busy === 1'b0) break;
      step();
    end
    auto_en = 1'b0;
    n_cmp++; if (start_log.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", start_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < start_log.size(); i++) begin
      n_cmp++;
      if (start_log[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_order[%0d]: got %h want %h", i, start_log[i], exp_q[i]); end
    end
    n_cmp++; if (dbl_start != 0)    begin n_fail++; $display("FAIL b2b_single_pulse: got %0d doubles want 0", dbl_start); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b want 0", overflow); end
    n_cmp++; if (empty !== 1'b1)    begin n_fail++; $display("FAIL b2b_empty: got %b want 1", empty); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst();
    test_fill_overflow();
    test_simultaneous();
    test_stray_tick();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within 500000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
